// File: rtl/button_input_pkg.sv
// Shared constants for the AHB button input block: register word offsets and HTRANS codes.
package button_input_pkg;

  localparam logic [1:0] REG_LEVEL    = 2'd0;
  localparam logic [1:0] REG_PRESSED  = 2'd1;
  localparam logic [1:0] REG_RELEASED = 2'd2;
  localparam logic [1:0] REG_IRQ_EN   = 2'd3;

  localparam logic [1:0] HTRANS_IDLE  = 2'b00;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, saturating debounce counter and the accepted level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter only advances while it is below CntLast, so it cannot wrap.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ahb_button_input.sv
// AHB-Lite slave exposing debounced button levels, sticky W1C press/release flags and an IRQ.
module ahb_button_input
  import button_input_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [31:0]     HADDR,
  input  logic [31:0]     HWDATA,
  input  logic [2:0]      HSIZE,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic            HREADY,
  input  logic            HSEL,
  output logic [31:0]     HRDATA,
  output logic            HREADYOUT,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] buttons_level,
  output logic            irq
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] level_prev_q;
  logic [N_CH-1:0] pressed_q, pressed_d;
  logic [N_CH-1:0] released_q, released_d;
  logic [N_CH-1:0] irq_en_q, irq_en_d;
  logic [N_CH-1:0] wdata;
  logic [N_CH-1:0] rdata_ch;
  logic            irq_q, irq_d;
  logic            accept;
  logic            wr_q, rd_q;
  logic [1:0]      addr_q;
  logic            unused_bus;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .raw   (buttons[g]),
      .level (level[g])
    );
  end

  assign accept = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
  assign wdata  = HWDATA[N_CH-1:0];

  // Clears are applied first and new edges OR-ed in afterwards, so a coincident edge wins.
  always_comb begin
    pressed_d  = pressed_q;
    released_d = released_q;
    irq_en_d   = irq_en_q;
    if (wr_q) begin
      case (addr_q)
        REG_PRESSED:  pressed_d  = pressed_q & ~wdata;
        REG_RELEASED: released_d = released_q & ~wdata;
        REG_IRQ_EN:   irq_en_d   = wdata;
        default:      ;
      endcase
    end
    pressed_d  = pressed_d | (level & ~level_prev_q);
    released_d = released_d | (~level & level_prev_q);
    irq_d      = |(irq_en_q & (pressed_q | released_q));
  end

  always_comb begin
    rdata_ch = '0;
    unique case (addr_q)
      REG_LEVEL:    rdata_ch = level;
      REG_PRESSED:  rdata_ch = pressed_q;
      REG_RELEASED: rdata_ch = released_q;
      REG_IRQ_EN:   rdata_ch = irq_en_q;
    endcase
    HRDATA = '0;
    if (rd_q) begin
      HRDATA[N_CH-1:0] = rdata_ch;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      level_prev_q <= '0;
      pressed_q    <= '0;
      released_q   <= '0;
      irq_en_q     <= '0;
      irq_q        <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      level_prev_q <= level;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      wr_q         <= accept && HWRITE;
      rd_q         <= accept && !HWRITE;
      addr_q       <= HADDR[3:2];
    end
  end

  assign HREADYOUT     = 1'b1;
  assign buttons_level = level;
  assign irq           = irq_q;

  // Only HADDR[3:2] and the low N_CH write bits carry meaning; HSIZE is ignored.
  assign unused_bus = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

endmodule

// File: tb/tb_ahb_button_input.sv
// Bench for ahb_button_input: directed scenarios plus random traffic against a window-based model.
module tb_ahb_button_input;

  localparam int unsigned NCh = 4;
  localparam int unsigned Deb = 4;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR, HWDATA, HRDATA;
  logic [2:0]      HSIZE;
  logic [1:0]      HTRANS;
  logic            HWRITE, HREADY, HSEL, HREADYOUT;
  logic [NCh-1:0]  buttons, buttons_level;
  logic            irq;

  int checks = 0;
  int errors = 0;

  // Reference model state: sync pipe, window of recent synchronised samples, registers.
  logic [NCh-1:0] m_s1, m_s2, m_lvl, m_lvl_old, m_pr, m_rl, m_en;
  logic           m_irq;
  logic           p_wr, p_rd;
  logic [1:0]     p_addr;
  logic [NCh-1:0] win[$];

  always #5 HCLK = ~HCLK;

  ahb_button_input #(
    .N_CH           (NCh),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HADDR        (HADDR),
    .HWDATA       (HWDATA),
    .HSIZE        (HSIZE),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HREADY       (HREADY),
    .HSEL         (HSEL),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .buttons      (buttons),
    .buttons_level(buttons_level),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[NCh-1:0] = m_lvl;
      2'd1: v[NCh-1:0] = m_pr;
      2'd2: v[NCh-1:0] = m_rl;
      default: v[NCh-1:0] = m_en;
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [NCh-1:0] npr, nrl, nen, nlvl;
    logic           all_diff;
    if (HRESET) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_old = '0;
      m_pr = '0; m_rl = '0; m_en = '0; m_irq = 1'b0;
      p_wr = 1'b0; p_rd = 1'b0; p_addr = '0;
      win.delete();
      return;
    end
    npr = m_pr; nrl = m_rl; nen = m_en;
    if (p_wr) begin
      if (p_addr == 2'd1) npr = npr & ~HWDATA[NCh-1:0];
      if (p_addr == 2'd2) nrl = nrl & ~HWDATA[NCh-1:0];
      if (p_addr == 2'd3) nen = HWDATA[NCh-1:0];
    end
    npr = npr | (m_lvl & ~m_lvl_old);
    nrl = nrl | (~m_lvl & m_lvl_old);
    // A level flips once the last Deb synchronised samples all disagree with it.
    win.push_back(m_s2);
    if (win.size() > Deb) void'(win.pop_front());
    nlvl = m_lvl;
    for (int c = 0; c < NCh; c++) begin
      if (win.size() == Deb) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i][c] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) nlvl[c] = ~m_lvl[c];
      end
    end
    m_irq     = |(m_en & (m_pr | m_rl));
    m_pr      = npr;
    m_rl      = nrl;
    m_en      = nen;
    m_lvl_old = m_lvl;
    m_lvl     = nlvl;
    m_s2      = m_s1;
    m_s1      = buttons;
    p_wr      = HSEL && HREADY && (HTRANS != 2'b00) && HWRITE;
    p_rd      = HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE;
    p_addr    = HADDR[3:2];
  endtask

  task automatic tick();
    model_edge();
    @(posedge HCLK);
    #1;
    check("level", {28'b0, buttons_level}, {28'b0, m_lvl});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("hrdata", HRDATA, p_rd ? m_reg(p_addr) : 32'h0);
    check("hreadyout", {31'b0, HREADYOUT}, 32'h1);
  endtask

  task automatic set_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    tick();
    set_idle();
    HWDATA = d;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    tick();
    d = HRDATA;
    set_idle();
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          hold[NCh];

    HRESET = 1'b1; HSIZE = 3'b010; HREADY = 1'b1; HWDATA = '0; buttons = '0;
    set_idle();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_old = '0;
    m_pr = '0; m_rl = '0; m_en = '0; m_irq = 1'b0;
    p_wr = 1'b0; p_rd = 1'b0; p_addr = '0;
    tick();
    tick();
    HRESET = 1'b0;

    // Reset state of every register.
    bus_read(32'h0, rd); check("rst_level", rd, 32'h0);
    bus_read(32'h4, rd); check("rst_pressed", rd, 32'h0);
    bus_read(32'h8, rd); check("rst_released", rd, 32'h0);
    bus_read(32'hC, rd); check("rst_irq_en", rd, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick();

    // Press latency on channel 1.
    buttons[1] = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (buttons_level[1]) n = i;
    end
    check("rise_latency", n, 6);
    tick();
    bus_read(32'h4, rd); check("pressed_ch1", rd, 32'h2);
    buttons[1] = 1'b0;
    repeat (10) tick();
    bus_write(32'h4, 32'hF);
    bus_write(32'h8, 32'hF);

    // Short glitch on channel 0 is rejected.
    buttons[0] = 1'b1;
    repeat (3) tick();
    buttons[0] = 1'b0;
    repeat (10) tick();
    bus_read(32'h0, rd); check("glitch_level", rd, 32'h0);
    bus_read(32'h4, rd); check("glitch_pressed", rd, 32'h0);

    // Interrupt path and W1C clear.
    bus_write(32'hC, 32'h1);
    buttons[0] = 1'b1;
    repeat (10) tick();
    buttons[0] = 1'b0;
    repeat (10) tick();
    bus_read(32'h4, rd); check("irq_pressed", rd, 32'h1);
    bus_read(32'h8, rd); check("irq_released", rd, 32'h1);
    check("irq_set", {31'b0, irq}, 32'h1);
    addr_phase(32'h4, 1'b1);
    tick();
    HWDATA = 32'h1;
    addr_phase(32'h8, 1'b1);
    tick();
    set_idle();
    HWDATA = 32'h1;
    tick();
    check("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("irq_clear", {31'b0, irq}, 32'h0);

    // W1C on PRESSED[2] at the same edge channel 2's rise is recorded.
    buttons[2] = 1'b1;
    repeat (5) tick();
    addr_phase(32'h4, 1'b1);
    tick();
    set_idle();
    HWDATA = 32'h4;
    tick();
    bus_read(32'h4, rd); check("set_beats_clear", rd, 32'h4);
    tick();

    // Reset mid-debounce on channel 3 and during a write data phase.
    buttons[3] = 1'b1;
    repeat (2) tick();
    addr_phase(32'hC, 1'b1);
    tick();
    tick();
    set_idle();
    HWDATA = 32'hF;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("rst_mid_level", {28'b0, buttons_level}, 32'h0);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (buttons_level[3]) n = i;
    end
    check("rst_restart_latency", n, 6);
    bus_read(32'hC, rd); check("rst_write_dropped", rd, 32'h0);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < NCh; c++) hold[c] = 1;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCh; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          buttons[c] = 1'($urandom);
          hold[c] = int'($urandom_range(1, 9));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        HSEL   = ($urandom_range(0, 3) != 0);
        HTRANS = 2'($urandom);
        HWRITE = 1'($urandom);
        HADDR  = $urandom;
      end else begin
        set_idle();
      end
      HWDATA = $urandom;
      HREADY = (p_wr || p_rd) ? 1'b1 : ($urandom_range(0, 3) != 0);
      HRESET = ($urandom_range(0, 249) == 0);
      tick();
    end
    HRESET = 1'b0;
    HREADY = 1'b1;
    set_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
